mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the core port, the debug/loader port and the
//                single-ported data-memory side of the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  // Core requester
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  // Debug / loader requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // Memory side
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // Requester / memory-model view
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (core / debug) round-robin arbiter in front of a
//                single-ported data memory. Write = 2 cycles, read = 3.
//                Illegal addresses are granted but never reach the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic        OWN_CORE  = 1'b0;
  localparam logic        OWN_DBG   = 1'b1;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // port being served
  logic        last_q,  last_d;    // port served most recently
  logic        we_q,    we_d;
  logic        ok_q,    ok_d;      // captured address is aligned and in range
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        winner;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        is_access;
  logic        is_resp;
  logic        mem_go;
  logic [31:0] resp_data;

  // Arbitration, next-state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    ok_d      = ok_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    // On a tie the port that was not served last wins
    if (bus.c_req && bus.d_req) begin
      winner = ~last_q;
    end else begin
      winner = bus.c_req ? OWN_CORE : OWN_DBG;
    end
    sel_we    = (winner == OWN_DBG) ? bus.d_we    : bus.c_we;
    sel_addr  = (winner == OWN_DBG) ? bus.d_addr  : bus.c_addr;
    sel_wdata = (winner == OWN_DBG) ? bus.d_wdata : bus.c_wdata;

    case (state_q)
      S_IDLE: begin
        if (bus.c_req || bus.d_req) begin
          owner_d = winner;
          last_d  = winner;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ok_d    = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = we_q ? S_IDLE : S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs depend only on registered state, never on a live request
    is_access = (state_q == S_ACCESS);
    is_resp   = (state_q == S_RESP);
    mem_go    = is_access && ok_q;
    // Dropped reads answer with zero instead of whatever the memory holds
    resp_data = ok_q ? bus.m_rdata : 32'h0;

    bus.c_gnt    = is_access && (owner_q == OWN_CORE);
    bus.d_gnt    = is_access && (owner_q == OWN_DBG);
    bus.c_rvalid = is_resp && (owner_q == OWN_CORE);
    bus.d_rvalid = is_resp && (owner_q == OWN_DBG);
    bus.c_rdata  = (is_resp && (owner_q == OWN_CORE)) ? resp_data : 32'h0;
    bus.d_rdata  = (is_resp && (owner_q == OWN_DBG))  ? resp_data : 32'h0;
    bus.m_en     = mem_go;
    bus.m_we     = mem_go && we_q;
    bus.m_addr   = mem_go ? addr_q  : 32'h0;
    bus.m_wdata  = mem_go ? wdata_q : 32'h0;
  end

  // State register; reset leaves debug as last owner so core wins first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_CORE;
      last_q  <= OWN_DBG;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios plus
//                randomized request groups against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MEM_BYTES = 1024;
  localparam int WORDS     = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory environment: registered read port, garbage when not read
  logic [31:0] tbmem [WORDS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) tbmem[i] <= init_word(i);
      bus.m_rdata <= $urandom;
    end else if (bus.m_en && (bus.m_addr < 32'(MEM_BYTES))) begin
      if (bus.m_we) tbmem[int'(bus.m_addr >> 2)] <= bus.m_wdata;
      bus.m_rdata <= bus.m_we ? $urandom : tbmem[int'(bus.m_addr >> 2)];
    end else begin
      bus.m_rdata <= $urandom;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          last_srv;            // 0 core, 1 debug
  bit          preq   [2];
  bit          pwe    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  int          pcnt   [2];
  int          order  [$];          // owners observed from the grants

  int checks = 0;
  int errors = 0;

  // Memory word i holds its own four byte addresses, low byte first
  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic bit is_legal(logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  function automatic logic gnt_of(int p);
    return (p == 0) ? bus.c_gnt : bus.d_gnt;
  endfunction

  function automatic logic rvalid_of(int p);
    return (p == 0) ? bus.c_rvalid : bus.d_rvalid;
  endfunction

  function automatic logic [31:0] rdata_of(int p);
    return (p == 0) ? bus.c_rdata : bus.d_rdata;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.c_req   = preq[0];
    bus.c_we    = pwe[0];
    bus.c_addr  = paddr[0];
    bus.c_wdata = pwdata[0];
    bus.d_req   = preq[1];
    bus.d_we    = pwe[1];
    bus.d_addr  = paddr[1];
    bus.d_wdata = pwdata[1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_ctrl"}, 32'({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid,
                              bus.m_en, bus.m_we}), 32'h0);
    chk({tag, "_rdata"}, bus.c_rdata | bus.d_rdata, 32'h0);
    chk({tag, "_mbus"}, bus.m_addr | bus.m_wdata, 32'h0);
  endtask

  task automatic init_ref();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    last_srv = 1;
  endtask

  task automatic new_fields(int p);
    int r;
    pwe[p]    = 1'($urandom_range(0, 1));
    pwdata[p] = $urandom;
    r = $urandom_range(0, 9);
    if (r < 7)       paddr[p] = 32'($urandom_range(0, WORDS - 1) * 4);
    else if (r == 7) paddr[p] = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
    else if (r == 8) paddr[p] = 32'(MEM_BYTES + 4 * $urandom_range(0, 63));
    else             paddr[p] = 32'hFFFF_FFFC;
  endtask

  // One transaction; entered in the ACCESS cycle, leaves in the following IDLE cycle
  task automatic serve_one();
    int          w;
    int          o;
    bit          legal;
    bit          is_rd;
    logic [31:0] exp_rd;
    if (preq[0] && preq[1]) w = (last_srv == 0) ? 1 : 0;
    else                    w = preq[0] ? 0 : 1;
    o        = 1 - w;
    last_srv = w;
    legal    = is_legal(paddr[w]);
    is_rd    = !pwe[w];
    exp_rd   = legal ? ref_mem[paddr[w] / 4] : 32'h0;

    if (bus.c_gnt) order.push_back(0);
    else if (bus.d_gnt) order.push_back(1);
    chk("gnt_owner",  32'(gnt_of(w)), 32'h1);
    chk("gnt_other",  32'(gnt_of(o)), 32'h0);
    chk("rvalid_acc", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
    chk("m_en",       32'(bus.m_en), 32'(legal));
    chk("m_we",       32'(bus.m_we), 32'(legal && pwe[w]));
    chk("m_addr",     bus.m_addr,  legal ? paddr[w]  : 32'h0);
    chk("m_wdata",    bus.m_wdata, legal ? pwdata[w] : 32'h0);
    if (legal && pwe[w]) ref_mem[paddr[w] / 4] = pwdata[w];

    pcnt[w]--;
    if (pcnt[w] > 0) new_fields(w);
    else             preq[w] = 1'b0;
    drive();
    step();

    if (is_rd) begin
      chk("rvalid_owner", 32'(rvalid_of(w)), 32'h1);
      chk("rvalid_other", 32'(rvalid_of(o)), 32'h0);
      chk("rdata_owner",  rdata_of(w), exp_rd);
      chk("rdata_other",  rdata_of(o), 32'h0);
      chk("resp_quiet",   32'({bus.c_gnt, bus.d_gnt, bus.m_en}), 32'h0);
      step();
    end
    check_quiet("idle");
  endtask

  // Entered and left in an IDLE cycle
  task automatic run_group();
    for (int p = 0; p < 2; p++) preq[p] = (pcnt[p] > 0);
    drive();
    step();
    while (preq[0] || preq[1]) begin
      serve_one();
      if (preq[0] || preq[1]) step();
    end
  endtask

  task automatic set_port(int p, int cnt, bit we, logic [31:0] a, logic [31:0] d);
    pcnt[p] = cnt; pwe[p] = we; paddr[p] = a; pwdata[p] = d;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) set_port(p, 0, 1'b0, 32'h0, 32'h0);
    preq[0] = 1'b0;
    preq[1] = 1'b0;
    drive();
    init_ref();

    // Reset: outputs quiet during and just after
    rst = 1'b1;
    step();
    check_quiet("in_reset");
    step();
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    // Core read of a known word
    set_port(0, 1, 1'b0, 32'h10, 32'h0);
    run_group();
    chk("core_read_ref", ref_mem[4], 32'h1312_1110);

    // Tie of writes right after reset: core first, then debug
    rst = 1'b1;
    step();
    rst = 1'b0;
    init_ref();
    step();
    order.delete();
    set_port(0, 1, 1'b1, 32'h20, 32'hC0DE_0001);
    set_port(1, 1, 1'b1, 32'h24, 32'hDEB0_0002);
    run_group();
    chk("tie_order_len", 32'(order.size()), 32'd2);
    if (order.size() == 2) chk("tie_order", 32'({order[0][0], order[1][0]}), 32'b01);
    // Read back both written words
    set_port(0, 1, 1'b0, 32'h20, 32'h0);
    run_group();
    set_port(1, 1, 1'b0, 32'h24, 32'h0);
    run_group();

    // Core streams three reads, debug asks once: core, debug, core, core
    order.delete();
    set_port(0, 3, 1'b0, 32'h40, 32'h0);
    set_port(1, 1, 1'b0, 32'h44, 32'h0);
    run_group();
    chk("rr_len", 32'(order.size()), 32'd4);
    if (order.size() == 4)
      chk("rr_order", 32'({order[0][0], order[1][0], order[2][0], order[3][0]}), 32'b0100);

    // Debug reads from misaligned and out-of-range addresses
    set_port(1, 1, 1'b0, 32'h3FE, 32'h0);
    run_group();
    set_port(1, 1, 1'b0, 32'h400, 32'h0);
    run_group();
    // A dropped write must not land anywhere
    set_port(0, 1, 1'b1, 32'h401, 32'hBAD0_BAD0);
    run_group();

    // Reset during the response cycle of a core read
    set_port(0, 1, 1'b0, 32'h30, 32'h0);
    preq[0] = 1'b1;
    drive();
    step();
    chk("abort_gnt", 32'(bus.c_gnt), 32'h1);
    preq[0] = 1'b0;
    pcnt[0] = 0;
    drive();
    step();
    chk("abort_resp_seen", 32'(bus.c_rvalid), 32'h1);
    rst = 1'b1;
    step();
    chk("abort_rvalid", 32'(bus.c_rvalid), 32'h0);
    check_quiet("abort_reset");
    rst = 1'b0;
    init_ref();
    step();
    check_quiet("abort_no_retry");
    order.delete();
    set_port(0, 1, 1'b1, 32'h50, 32'h1111_2222);
    set_port(1, 1, 1'b1, 32'h54, 32'h3333_4444);
    run_group();
    if (order.size() > 0) chk("abort_tie_core", 32'(order[0]), 32'd0);
    else                  chk("abort_tie_core", 32'hFFFF_FFFF, 32'd0);

    // Randomized request groups
    for (int g = 0; g < 40; g++) begin
      for (int p = 0; p < 2; p++) begin
        new_fields(p);
        pcnt[p] = $urandom_range(0, 2);
      end
      if (pcnt[0] == 0 && pcnt[1] == 0) pcnt[$urandom_range(0, 1)] = 1;
      run_group();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
